// File: rtl/iq_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : iq_stream_packer
// Description : Packs wide signed I/Q filter samples into a narrow host bus.
//               Each sample is truncated to OUT_W bits (sign kept, GUARD bits
//               below the sign discarded). The truncated pairs are buffered in
//               a 2**DEPTH_LOG2 pair FIFO. They are then handed to the host
//               as two words, I first and then Q. Each word uses a
//               DATA_RDY / DATA_ACK (active-low) four-phase handshake. The
//               host can throttle the transfer with FLAG_F (active-low
//               "host FIFO full").
//
// Ports       : CIC_CLK   in   1             sole clock, rising edge
//               RST       in   1             synchronous active-high reset
//               IN_I      in   IN_W          signed I sample
//               IN_Q      in   IN_W          signed Q sample
//               IN_VLD    in   1             strobe qualifying IN_I/IN_Q
//               OUT       out  OUT_W         word presented to the host
//               DATA_RDY  out  1             OUT is valid
//               DATA_ACK  in   1             active-low host read strobe
//               FLAG_F    in   1             active-low host-FIFO-full flag
//               FIFO_LVL  out  DEPTH_LOG2+1  number of stored pairs
//               OVF_CNT   out  16            dropped pairs, saturating
//
// Build option: IQ_PACK_SAT_EN - when defined, truncation saturates to the
//               most positive / most negative OUT_W value when a discarded
//               guard bit disagrees with the sign. When undefined, the
//               plain bit selection wraps silently.
//
// Revision    : 1.0 - initial release
// ============================================================================
module iq_stream_packer #(
    parameter int IN_W       = 34,
    parameter int OUT_W      = 16,
    parameter int GUARD      = 2,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CIC_CLK,
    input  logic                  RST,
    input  logic [IN_W-1:0]       IN_I,
    input  logic [IN_W-1:0]       IN_Q,
    input  logic                  IN_VLD,
    output logic [OUT_W-1:0]      OUT,
    output logic                  DATA_RDY,
    input  logic                  DATA_ACK,
    input  logic                  FLAG_F,
    output logic [DEPTH_LOG2:0]   FIFO_LVL,
    output logic [15:0]           OVF_CNT
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_ONE  = (DEPTH_LOG2+1)'(1);

    // Host handshake states
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SEND_I = 3'd1;
    localparam logic [2:0] c_ST_REL_I  = 3'd2;
    localparam logic [2:0] c_ST_SEND_Q = 3'd3;
    localparam logic [2:0] c_ST_REL_Q  = 3'd4;

    // ------------------------------------------------------------------------
    // Truncation: keep the sign, skip GUARD bits under it, keep the next
    // OUT_W-1 bits. With saturation enabled, a guard bit that disagrees
    // with the sign means the value does not fit. It is then clamped
    // towards the sign.
    // ------------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] f_trunc(input logic [IN_W-1:0] s);
        logic [OUT_W-1:0] v;
        v = {s[IN_W-1], s[IN_W-2-GUARD -: OUT_W-1]};
`ifdef IQ_PACK_SAT_EN
        if (s[IN_W-2 -: GUARD] != {GUARD{s[IN_W-1]}}) begin
            v = {s[IN_W-1], {(OUT_W-1){~s[IN_W-1]}}};
        end
`endif
        return v;
    endfunction

    logic [OUT_W-1:0]   w_i_tr;
    logic [OUT_W-1:0]   w_q_tr;
    logic               w_unused;

    assign w_i_tr   = f_trunc(IN_I);
    assign w_q_tr   = f_trunc(IN_Q);
    // Only a slice of every sample reaches the output; the rest is
    // intentionally ignored.
    assign w_unused = ^{IN_I, IN_Q};

    // ------------------------------------------------------------------------
    // Pair FIFO. Each entry is {I, Q}. The storage is not reset because the
    // pointers and the level fully define which entries are valid.
    // ------------------------------------------------------------------------
    logic [2*OUT_W-1:0]     r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_lvl;
    logic [15:0]            r_ovf;

    logic [2:0]             r_state;
    logic [OUT_W-1:0]       r_out;
    logic                   r_rdy;
    logic [OUT_W-1:0]       r_q_hold;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic [2*OUT_W-1:0]     w_rd_data;

    assign w_full    = (r_lvl == c_FULL);
    // A pair leaves the FIFO only when the handshake is idle and the host
    // can take data.
    assign w_pop     = (r_state == c_ST_IDLE) && (r_lvl != '0) && FLAG_F;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_wr      = IN_VLD && (!w_full || w_pop);
    assign w_drop    = IN_VLD && w_full && !w_pop;
    assign w_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge CIC_CLK) begin
        if (w_wr && !RST) begin
            r_mem[r_wr_ptr] <= {w_i_tr, w_q_tr};
        end
    end

    // Pointers are DEPTH_LOG2 wide, so they wrap modulo the depth on their
    // own.
    always_ff @(posedge CIC_CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_lvl <= r_lvl + c_ONE;
                2'b01:   r_lvl <= r_lvl - c_ONE;
                default: r_lvl <= r_lvl;
            endcase
            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Host handshake. OUT is loaded only in IDLE (on a pop) and in REL_I
    // (Q word). DATA_RDY is low in both places, so OUT never moves while
    // DATA_RDY is high. Q is held aside on the pop, so a pair is always
    // delivered as a unit.
    // ------------------------------------------------------------------------
    always_ff @(posedge CIC_CLK) begin
        if (RST) begin
            r_state  <= c_ST_IDLE;
            r_out    <= '0;
            r_rdy    <= 1'b0;
            r_q_hold <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_out    <= w_rd_data[2*OUT_W-1:OUT_W];
                        r_q_hold <= w_rd_data[OUT_W-1:0];
                        r_rdy    <= 1'b1;
                        r_state  <= c_ST_SEND_I;
                    end
                end
                c_ST_SEND_I, c_ST_SEND_Q: begin
                    // An ACK counts only against a word the host could
                    // actually see, so a throttled (RDY low) word is not
                    // consumed by an ACK arriving together with FLAG_F low.
                    if (!DATA_ACK && r_rdy) begin
                        r_rdy   <= 1'b0;
                        r_state <= (r_state == c_ST_SEND_I) ? c_ST_REL_I
                                                            : c_ST_REL_Q;
                    end else if (!FLAG_F) begin
                        r_rdy <= 1'b0;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                c_ST_REL_I: begin
                    if (DATA_ACK) begin
                        r_out   <= r_q_hold;
                        r_rdy   <= 1'b1;
                        r_state <= c_ST_SEND_Q;
                    end
                end
                c_ST_REL_Q: begin
                    if (DATA_ACK) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign OUT      = r_out;
    assign DATA_RDY = r_rdy;
    assign FIFO_LVL = r_lvl;
    assign OVF_CNT  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_iq_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_stream_packer
// Description : Directed self-checking bench for iq_stream_packer (default
//               parameters). A queue-based model predicts OUT, DATA_RDY,
//               FIFO_LVL and OVF_CNT after every edge. Literal expectations
//               pin the key scenarios. Honours IQ_PACK_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_stream_packer;

    logic        CIC_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [33:0] IN_I = '0;
    logic [33:0] IN_Q = '0;
    logic        IN_VLD = 1'b0;
    logic [15:0] OUT;
    logic        DATA_RDY;
    logic        DATA_ACK = 1'b1;
    logic        FLAG_F = 1'b1;
    logic [3:0]  FIFO_LVL;
    logic [15:0] OVF_CNT;

    iq_stream_packer dut (
        .CIC_CLK  (CIC_CLK),
        .RST      (RST),
        .IN_I     (IN_I),
        .IN_Q     (IN_Q),
        .IN_VLD   (IN_VLD),
        .OUT      (OUT),
        .DATA_RDY (DATA_RDY),
        .DATA_ACK (DATA_ACK),
        .FLAG_F   (FLAG_F),
        .FIFO_LVL (FIFO_LVL),
        .OVF_CNT  (OVF_CNT)
    );

    always #5 CIC_CLK = ~CIC_CLK;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------------
    // Model: list of stored pairs plus the handshake phase of the pair in
    // flight (0 idle, 1 I offered, 2 I taken, 3 Q offered, 4 Q taken).
    // ------------------------------------------------------------------------
    logic [31:0] m_q[$];
    int          m_phase = 0;
    logic        m_rdy   = 1'b0;
    logic [15:0] m_out   = '0;
    logic [15:0] m_qword = '0;
    logic [15:0] m_ovf   = '0;

    // Sign, then skip bits 32:31, then bits 30:16.
    function automatic logic [15:0] m_trunc(input logic [33:0] s);
        logic [33:0] t;
        logic        sgn;
        logic [1:0]  g;
        logic [15:0] r;
        sgn = s[33];
        g   = s[32:31];
        t   = s >> 16;
        r   = {sgn, t[14:0]};
`ifdef IQ_PACK_SAT_EN
        if (g != {2{sgn}}) r = sgn ? 16'h8000 : 16'h7FFF;
`else
        if (g == 2'b11) r = r;
`endif
        return r;
    endfunction

    task automatic model_step();
        logic        pop;
        logic [31:0] pair;
        if (RST) begin
            m_q.delete();
            m_phase = 0;
            m_rdy   = 1'b0;
            m_out   = '0;
            m_ovf   = '0;
        end else begin
            pop  = (m_phase == 0) && (m_q.size() != 0) && FLAG_F;
            pair = '0;
            if (pop) pair = m_q.pop_front();
            case (m_phase)
                0: if (pop) begin
                    m_out = pair[31:16]; m_qword = pair[15:0];
                    m_rdy = 1'b1; m_phase = 1;
                end
                1, 3: begin
                    if (!DATA_ACK && m_rdy) begin
                        m_rdy = 1'b0; m_phase = m_phase + 1;
                    end else begin
                        m_rdy = FLAG_F;
                    end
                end
                2: if (DATA_ACK) begin
                    m_out = m_qword; m_rdy = 1'b1; m_phase = 3;
                end
                default: if (DATA_ACK) m_phase = 0;
            endcase
            if (IN_VLD) begin
                if (m_q.size() < 8) m_q.push_back({m_trunc(IN_I), m_trunc(IN_Q)});
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("DATA_RDY", 32'(DATA_RDY), 32'(m_rdy));
        chk("OUT",      32'(OUT),      32'(m_out));
        chk("FIFO_LVL", 32'(FIFO_LVL), 32'(m_q.size()));
        chk("OVF_CNT",  32'(OVF_CNT),  32'(m_ovf));
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare 1 time unit later.
    task automatic cyc(input logic rst, input logic vld, input logic [33:0] i,
                       input logic [33:0] q, input logic ack, input logic flag);
        @(negedge CIC_CLK);
        RST = rst; IN_VLD = vld; IN_I = i; IN_Q = q; DATA_ACK = ack; FLAG_F = flag;
        @(posedge CIC_CLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input logic ack, input logic flag);
        cyc(1'b0, 1'b0, '0, '0, ack, flag);
    endtask

    // Pair k: I truncates to k, Q truncates to -k.
    function automatic logic [33:0] ti(input int k);
        return 34'(k) << 16;
    endfunction
    function automatic logic [33:0] tq(input int k);
        return -(34'(k) << 16);
    endfunction

    initial begin
        // Reset, with a strobe that must be ignored
        cyc(1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, ti(5), tq(5), 1'b1, 1'b1);
        chk("rst_lvl", 32'(FIFO_LVL), 32'd0);
        chk("rst_rdy", 32'(DATA_RDY), 32'd0);
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_ovf", 32'(OVF_CNT), 32'd0);

        // Basic pair: two-edge latency, then I and Q words
        cyc(1'b0, 1'b1, 34'h0_1234_0000, 34'h3_FFFF_0000, 1'b1, 1'b1);
        chk("lat_rdy_early", 32'(DATA_RDY), 32'd0);
        idle(1'b1, 1'b1);
        chk("lat_rdy", 32'(DATA_RDY), 32'd1);
        chk("i_word", 32'(OUT), 32'h1234);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        chk("q_word", 32'(OUT), 32'hFFFF);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // Overfill: 10 strobes with no ACK
        for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b1, ti(k), tq(k), 1'b1, 1'b1);
        chk("fill_lvl", 32'(FIFO_LVL), 32'd8);
        chk("fill_ovf", 32'(OVF_CNT), 32'd1);
        chk("fill_out", 32'(OUT), 32'h0001);

        // Finish pair 1 and throttle with FLAG_F while Q is offered
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        chk("thr_rdy", 32'(DATA_RDY), 32'd0);
        chk("thr_out", 32'(OUT), 32'hFFFF);
        idle(1'b1, 1'b1);
        chk("thr_rdy2", 32'(DATA_RDY), 32'd1);
        chk("thr_out2", 32'(OUT), 32'hFFFF);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // Full FIFO: strobe on the same edge as a pop
        cyc(1'b0, 1'b1, ti(11), tq(11), 1'b1, 1'b1);
        chk("pp_lvl", 32'(FIFO_LVL), 32'd8);
        chk("pp_ovf", 32'(OVF_CNT), 32'd1);
        chk("pp_out", 32'(OUT), 32'h0002);

        // ACK while throttled does not consume the word; an ACK while RDY is
        // high wins over FLAG_F low
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        chk("ackthr_rdy", 32'(DATA_RDY), 32'd0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // Drain the remaining pairs in order (model checks every word)
        repeat (9) begin
            idle(1'b1, 1'b1);
            idle(1'b0, 1'b1);
            idle(1'b1, 1'b1);
            idle(1'b0, 1'b1);
            idle(1'b1, 1'b1);
        end
        chk("drain_lvl", 32'(FIFO_LVL), 32'd0);

        // Reset mid-frame (in REL_I with 3 pairs queued)
        for (int k = 20; k < 24; k++) cyc(1'b0, 1'b1, ti(k), tq(k), 1'b1, 1'b1);
        idle(1'b0, 1'b1);
        chk("mid_lvl_pre", 32'(FIFO_LVL), 32'd3);
        cyc(1'b1, 1'b1, ti(30), tq(30), 1'b1, 1'b1);
        chk("mid_lvl", 32'(FIFO_LVL), 32'd0);
        chk("mid_rdy", 32'(DATA_RDY), 32'd0);
        idle(1'b1, 1'b1);
        chk("mid_idle", 32'(DATA_RDY), 32'd0);

        // Guard-bit overflow: saturate or wrap depending on build
        cyc(1'b0, 1'b1, 34'h0_8000_0000, 34'h3_7FFF_0000, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
`ifdef IQ_PACK_SAT_EN
        chk("sat_i", 32'(OUT), 32'h7FFF);
`else
        chk("sat_i", 32'(OUT), 32'h0000);
`endif
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
`ifdef IQ_PACK_SAT_EN
        chk("sat_q", 32'(OUT), 32'h8000);
`else
        chk("sat_q", 32'(OUT), 32'hFFFF);
`endif
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // A few arbitrary sample patterns through the model
        cyc(1'b0, 1'b1, 34'h2_ABCD_1234, 34'h1_5555_AAAA, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 34'h0_7FFF_FFFF, 34'h3_8000_0001, 1'b1, 1'b1);
        repeat (2) begin
            idle(1'b0, 1'b1);
            idle(1'b1, 1'b1);
            idle(1'b0, 1'b1);
            idle(1'b1, 1'b1);
            idle(1'b1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
